// File: rtl/seq_mul_div.sv
// rtl/seq_mul_div.sv - iterative signed/unsigned multiply/divide unit
//
// Accepts one MUL/MULH/DIV/REM request at a time and returns the result
// after WIDTH+1 cycles. Division by zero and signed overflow follow the
// RISC-V M rules.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  request handshake (in_ready high only in IDLE)
//   op                   00 MUL, 01 MULH, 10 DIV, 11 REM
//   is_signed            two's-complement operands when 1
//   a, b                 multiplicand/dividend, multiplier/divisor
//   out_valid/out_ready  result handshake
//   result, div_zero     result word, DIV/REM by zero flag
//
// Optional feature: define SEQ_MUL_DIV_EARLY_OUT_EN to finish trivial
// operations (divide by zero, multiply by zero) directly from IDLE.

module seq_mul_div #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             div_zero
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [1:0] OP_MUL  = 2'b00;
   localparam logic [1:0] OP_MULH = 2'b01;
   localparam logic [1:0] OP_DIV  = 2'b10;
   localparam logic [1:0] OP_REM  = 2'b11;

   logic [1:0]         state;
   logic [1:0]         op_q;
   logic               neg_res;   // product/quotient must be negated
   logic               neg_rem;   // dividend was negative
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] acc;       // multiply accumulator {high, multiplier}
   logic [WIDTH-1:0]   quo;       // dividend shifting out, quotient in
   logic [WIDTH-1:0]   rem;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);

   // Operand magnitudes and signs at accept time.
   logic             a_neg, b_neg;
   logic [WIDTH-1:0] abs_a, abs_b;
   assign a_neg = is_signed & a[WIDTH-1];
   assign b_neg = is_signed & b[WIDTH-1];
   assign abs_a = a_neg ? -a : a;
   assign abs_b = b_neg ? -b : b;

   // Shift-add step: add the multiplicand into the high half when the
   // current multiplier bit is set, then shift the whole accumulator right.
   logic [WIDTH:0] mul_sum;
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);

   // Restoring-division step on the WIDTH+1-bit partial remainder. Since
   // rem_sh < 2*mag_b, the top bit of the difference is a reliable borrow.
   logic [WIDTH:0] rem_sh;
   logic [WIDTH:0] rem_diff;
   logic           rem_ge;
   assign rem_sh   = {rem, quo[WIDTH-1]};
   assign rem_diff = rem_sh - {1'b0, mag_b};
   assign rem_ge   = ~rem_diff[WIDTH];

   // Sign correction and result selection. Signed MIN / -1 needs no
   // special handling: |MIN| / 1 = MIN with equal signs, remainder 0.
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo_s, rem_s, a_orig, fix_res;
   logic               b_zero;
   assign prod   = neg_res ? -acc : acc;
   assign quo_s  = neg_res ? -quo : quo;
   assign rem_s  = neg_rem ? -rem : rem;
   assign a_orig = neg_rem ? -mag_a : mag_a;
   assign b_zero = (mag_b == '0);

   always_comb begin
      fix_res = '0;
      case (op_q)
         OP_MUL:  fix_res = prod[WIDTH-1:0];
         OP_MULH: fix_res = prod[2*WIDTH-1:WIDTH];
         OP_DIV:  fix_res = b_zero ? '1 : quo_s;
         OP_REM:  fix_res = b_zero ? a_orig : rem_s;
         default: fix_res = '0;
      endcase
   end

`ifdef SEQ_MUL_DIV_EARLY_OUT_EN
   logic             early;
   logic [WIDTH-1:0] early_res;
   always_comb begin
      early     = op[1] ? (b == '0) : ((a == '0) || (b == '0));
      early_res = '0;
      case (op)
         OP_DIV:  early_res = '1;
         OP_REM:  early_res = a;
         default: early_res = '0;
      endcase
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         op_q     <= '0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         mag_a    <= '0;
         mag_b    <= '0;
         cnt      <= '0;
         acc      <= '0;
         quo      <= '0;
         rem      <= '0;
         result   <= '0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_q    <= op;
                  neg_res <= a_neg ^ b_neg;
                  neg_rem <= a_neg;
                  mag_a   <= abs_a;
                  mag_b   <= abs_b;
                  cnt     <= '0;
                  acc     <= {{WIDTH{1'b0}}, abs_b};
                  quo     <= abs_a;
                  rem     <= '0;
`ifdef SEQ_MUL_DIV_EARLY_OUT_EN
                  if (early) begin
                     result   <= early_res;
                     div_zero <= op[1];
                     state    <= S_DONE;
                  end else begin
                     state <= S_RUN;
                  end
`else
                  state <= S_RUN;
`endif
               end
            end
            S_RUN: begin
               if (op_q[1]) begin
                  rem <= rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], rem_ge};
               end else begin
                  acc <= {mul_sum, acc[WIDTH-1:1]};
               end
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH-1)) begin
                  state <= S_FIX;
               end
            end
            S_FIX: begin
               result   <= fix_res;
               div_zero <= op_q[1] & b_zero;
               state    <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mul_div.sv
// tb/tb_seq_mul_div.sv - self-checking bench for seq_mul_div (WIDTH=32)

module tb_seq_mul_div;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    op = 2'b00;
   logic          is_signed = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  result;
   logic          div_zero;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_mul_div #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .div_zero  (div_zero)
   );

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: plain 64-bit / native integer arithmetic.
   function automatic void model(input logic [1:0] o, input logic s,
                                 input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] r, output logic dz);
      longint          sx, sy;
      longint unsigned p;
      int              si, sj;
      dz = 1'b0;
      r  = '0;
      if (!o[1]) begin
         if (s) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            p  = sx * sy;
         end else begin
            p = {32'b0, x} * {32'b0, y};
         end
         r = o[0] ? p[63:32] : p[31:0];
      end else if (y == 0) begin
         dz = 1'b1;
         r  = o[0] ? x : 32'hFFFF_FFFF;
      end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
         r = o[0] ? 32'h0 : x;
      end else if (s) begin
         si = $signed(x);
         sj = $signed(y);
         r  = o[0] ? (si % sj) : (si / sj);
      end else begin
         r = o[0] ? (x % y) : (x / y);
      end
   endfunction

   function automatic int exp_latency(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      int lat;
      lat = W + 1;
`ifdef SEQ_MUL_DIV_EARLY_OUT_EN
      if (o[1] ? (y == 0) : (x == 0 || y == 0)) lat = 0;
`else
      if (o == 2'b11 && x == 0 && y == 0) lat = W + 1;
`endif
      return lat;
   endfunction

   task automatic do_op(input logic [1:0] o, input logic s, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int hold);
      logic [W-1:0] er;
      logic         edz;
      int           lat;
      model(o, s, x, y, er, edz);
      @(negedge clk);
      check("in_ready_idle", W'(in_ready), W'(1));
      op = o; is_signed = s; a = x; b = y; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // scramble inputs: they must be ignored while busy
      op = 2'($urandom); is_signed = 1'($urandom); a = $urandom; b = $urandom;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check($sformatf("latency op%0d", o), W'(lat), W'(exp_latency(o, x, y)));
      check($sformatf("result op%0d s%0d %h %h", o, s, x, y), result, er);
      check("div_zero", W'(div_zero), W'(edz));
      check("in_ready_busy", W'(in_ready), W'(0));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check("hold_result", result, er);
         check("hold_out_valid", W'(out_valid), W'(1));
         check("hold_in_ready", W'(in_ready), W'(0));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("in_ready_after", W'(in_ready), W'(1));
      check("out_valid_after", W'(out_valid), W'(0));
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", W'(in_ready), W'(1));
      check("rst_out_valid", W'(out_valid), W'(0));
      check("rst_result", result, '0);
      check("rst_div_zero", W'(div_zero), W'(0));
      @(negedge clk);
      rst_n = 1'b1;

      do_op(2'b00, 1'b1, 32'd7, 32'hFFFF_FFFD, 0);
      do_op(2'b01, 1'b1, 32'd7, 32'hFFFF_FFFD, 0);
      do_op(2'b10, 1'b0, 32'd100, 32'd7, 5);
      do_op(2'b11, 1'b0, 32'd100, 32'd7, 0);
      do_op(2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
      do_op(2'b11, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
      do_op(2'b10, 1'b0, 32'h1234_5678, 32'd0, 1);
      do_op(2'b11, 1'b0, 32'h1234_5678, 32'd0, 0);
      do_op(2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op(2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      do_op(2'b00, 1'b0, 32'd0, 32'd5, 0);

      // reset during iteration 10 of a DIV
      @(negedge clk);
      op = 2'b10; is_signed = 1'b0; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", W'(in_ready), W'(1));
      check("abort_out_valid", W'(out_valid), W'(0));
      check("abort_result", result, '0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      check("abort_no_result", W'(seen), W'(0));
      do_op(2'b00, 1'b0, 32'd6, 32'd7, 0);

      for (int n = 0; n < 40; n++) begin
         do_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pick(), pick(),
               $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
